// File: rtl/i2c_init_sequencer.sv
// I2C init sequencer: issues each 24-bit table entry as a three-frame register write.
// Define I2C_SEQ_TIMEOUT_EN to abort a hung frame after TIMEOUT_US cycles.

module i2c_init_sequencer #(
  parameter int NUM_CMDS   = 8,
  parameter int ADDR_W     = 3,
  parameter int GAP_US     = 1000,
  parameter int TIMEOUT_US = 2000
) (
  input  logic              clk_1MHz,
  input  logic              rst_n,
  input  logic              go,
  output logic [ADDR_W-1:0] cmd_addr,
  input  logic [23:0]       cmd_data,
  output logic              wf_en_write,
  output logic              wf_start_frame,
  output logic              wf_stop_frame,
  output logic [7:0]        wf_data,
  input  logic              wf_done,
  output logic              wf_rst_n,
  output logic              busy,
  output logic              init_done,
  output logic              error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_SEND,
    S_WAIT,
    S_GAP,
    S_FINISH
  } state_t;

  localparam int GW = (GAP_US > 1) ? $clog2(GAP_US) : 1;
  localparam logic [GW-1:0] GAP_LAST =
    GW'((GAP_US > 0) ? GAP_US - 1 : 0);
  localparam logic [ADDR_W-1:0] LAST_ADDR =
    ADDR_W'(NUM_CMDS - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_d;
  logic [6:0]        dev_q, dev_d;
  logic [7:0]        reg_q, reg_d;
  logic [7:0]        val_q, val_d;
  logic [1:0]        idx_q, idx_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic              en_d, start_d, stop_d;
  logic [7:0]        data_d;
  logic              busy_d, init_d, err_d;

  logic unused_ok;
  assign unused_ok = cmd_data[16] ^ (TIMEOUT_US < 0);

`ifdef I2C_SEQ_TIMEOUT_EN
  localparam int TW = (TIMEOUT_US > 1) ? $clog2(TIMEOUT_US) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_US - 1);

  logic [TW-1:0] to_q, to_d;
  logic          abort_q, abort_d;

  assign wf_rst_n = rst_n & ~abort_q;
`else
  assign wf_rst_n = rst_n;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = cmd_addr;
    dev_d   = dev_q;
    reg_d   = reg_q;
    val_d   = val_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    en_d    = 1'b0;
    data_d  = wf_data;
    start_d = wf_start_frame;
    stop_d  = wf_stop_frame;
    busy_d  = busy;
    init_d  = init_done;
    err_d   = error;
`ifdef I2C_SEQ_TIMEOUT_EN
    abort_d = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (go) begin
          state_d = S_FETCH;
          addr_d  = '0;
          busy_d  = 1'b1;
          init_d  = 1'b0;
          err_d   = 1'b0;
        end
      end
      S_FETCH: state_d = S_LATCH;
      S_LATCH: begin
        dev_d   = cmd_data[23:17];
        reg_d   = cmd_data[15:8];
        val_d   = cmd_data[7:0];
        idx_d   = 2'd0;
        state_d = S_SEND;
        en_d    = 1'b1;
        data_d  = {cmd_data[23:17], 1'b0};
        start_d = 1'b1;
        stop_d  = 1'b0;
      end
      S_SEND: state_d = S_WAIT;
      S_WAIT: begin
        if (wf_done) begin
          if (idx_q != 2'd2) begin
            idx_d   = idx_q + 2'd1;
            state_d = S_SEND;
            en_d    = 1'b1;
            data_d  = (idx_q == 2'd0) ? reg_q : val_q;
            start_d = 1'b0;
            stop_d  = (idx_q == 2'd1);
          end else if (cmd_addr == LAST_ADDR) begin
            state_d = S_FINISH;
          end else if (GAP_US == 0) begin
            state_d = S_FETCH;
            addr_d  = cmd_addr + 1'b1;
          end else begin
            state_d = S_GAP;
            gap_d   = '0;
          end
        end
`ifdef I2C_SEQ_TIMEOUT_EN
        else if (to_q == TO_LAST) begin
          // writeframe is stuck (e.g. NAK): kick it and give up
          abort_d = 1'b1;
          err_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
`endif
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = S_FETCH;
          addr_d  = cmd_addr + 1'b1;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        init_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
`ifdef I2C_SEQ_TIMEOUT_EN
    to_d = to_q;
    if (en_d)
      to_d = '0;
    else if (state_q == S_SEND || state_q == S_WAIT)
      to_d = to_q + 1'b1;
`endif
  end

  always_ff @(posedge clk_1MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      cmd_addr       <= '0;
      dev_q          <= '0;
      reg_q          <= '0;
      val_q          <= '0;
      idx_q          <= '0;
      gap_q          <= '0;
      wf_en_write    <= 1'b0;
      wf_start_frame <= 1'b0;
      wf_stop_frame  <= 1'b0;
      wf_data        <= '0;
      busy           <= 1'b0;
      init_done      <= 1'b0;
      error          <= 1'b0;
    end else begin
      state_q        <= state_d;
      cmd_addr       <= addr_d;
      dev_q          <= dev_d;
      reg_q          <= reg_d;
      val_q          <= val_d;
      idx_q          <= idx_d;
      gap_q          <= gap_d;
      wf_en_write    <= en_d;
      wf_start_frame <= start_d;
      wf_stop_frame  <= stop_d;
      wf_data        <= data_d;
      busy           <= busy_d;
      init_done      <= init_d;
      error          <= err_d;
    end
  end

`ifdef I2C_SEQ_TIMEOUT_EN
  always_ff @(posedge clk_1MHz or negedge rst_n) begin
    if (!rst_n) begin
      to_q    <= '0;
      abort_q <= 1'b0;
    end else begin
      to_q    <= to_d;
      abort_q <= abort_d;
    end
  end
`endif

endmodule
